// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage.
// Drives a word address into a combinational instruction memory and captures
// the returned instruction into the IF/ID register. It handles decode stalls
// and execute-stage redirects. A fetched HALT drains the pipeline with a fixed
// number of bubble cycles and then parks the unit until reset.
//
// Handshake: the decode side has no valid/ready pair. D_Valid qualifies
// D_Instr/D_PC, and D_Stall is a hold request. While D_Stall=1 (and no
// redirect), every fetch-side register keeps its value, so the same D_Instr
// is presented again on the next cycle. X_Redirect is sampled on each rising
// edge and takes priority over D_Stall.
module instruction_fetch_unit #(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          INSTR_WIDTH  = 32,
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int          PC_STEP      = 1,
  parameter logic [5:0]  HALT_OPCODE  = 6'h11,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  F_PC,
  input  logic [INSTR_WIDTH-1:0] Instr,
  input  logic                   D_Stall,
  input  logic                   X_Redirect,
  input  logic [ADDR_WIDTH-1:0]  X_Target,
  output logic [INSTR_WIDTH-1:0] D_Instr,
  output logic [ADDR_WIDTH-1:0]  D_PC,
  output logic                   D_Valid,
  output logic                   Halted,
  output logic [31:0]            FetchCount,
  output logic [1:0]             Dbg_State
);

  // Fetch controller states. The encoding is visible on Dbg_State:
  // 0 = RUN, 1 = DRAIN, 2 = HALTED.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  fpc_q;
  logic [INSTR_WIDTH-1:0] dinstr_q;
  logic [ADDR_WIDTH-1:0]  dpc_q;
  logic                   dvalid_q;
  logic                   halted_q;
  logic [31:0]            count_q;
  logic [3:0]             drain_q;

  // Next sequential fetch address and HALT detection on the memory response.
  logic [ADDR_WIDTH-1:0]  fpc_inc_d;
  logic                   is_halt_d;

  // Sequential PC wraps naturally at 2^ADDR_WIDTH; HALT is the top opcode field.
  always_comb begin
    fpc_inc_d = fpc_q + ADDR_WIDTH'(PC_STEP);
    is_halt_d = (Instr[31:26] == HALT_OPCODE);
  end

  // Single controller block: reset > redirect > stall > normal, per state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      fpc_q    <= ADDR_WIDTH'(RESET_PC);
      dinstr_q <= '0;
      dpc_q    <= '0;
      dvalid_q <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
      drain_q  <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (X_Redirect) begin
            // Wrong-path instruction on Instr is dropped, even if it is a HALT.
            fpc_q    <= X_Target;
            dvalid_q <= 1'b0;
            dinstr_q <= '0;
          end else if (!D_Stall) begin
            dinstr_q <= Instr;
            dpc_q    <= fpc_q;
            dvalid_q <= 1'b1;
            count_q  <= count_q + 32'd1;
            if (is_halt_d) begin
              // PC stays on the HALT so nothing past it is ever fetched.
              state_q <= ST_DRAIN;
              drain_q <= 4'(DRAIN_CYCLES);
            end else begin
              fpc_q <= fpc_inc_d;
            end
          end
        end

        ST_DRAIN: begin
          if (X_Redirect) begin
            // An older branch squashes the HALT; resume normal fetch.
            fpc_q    <= X_Target;
            dvalid_q <= 1'b0;
            dinstr_q <= '0;
            drain_q  <= '0;
            state_q  <= ST_RUN;
          end else if (!D_Stall) begin
            // Decode has taken the HALT; issue bubbles until the count runs out.
            dvalid_q <= 1'b0;
            dinstr_q <= '0;
            drain_q  <= drain_q - 4'd1;
            if (drain_q == 4'd1) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end
          end
        end

        ST_HALTED: begin
          // Parked: only reset leaves this state.
          halted_q <= 1'b1;
          dvalid_q <= 1'b0;
        end

        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // All outputs come straight from registers.
  assign F_PC       = fpc_q;
  assign D_Instr    = dinstr_q;
  assign D_PC       = dpc_q;
  assign D_Valid    = dvalid_q;
  assign Halted     = halted_q;
  assign FetchCount = count_q;
  assign Dbg_State  = state_q;

endmodule
